// File: rtl/aes_arb_pkg.sv
// Shared definitions for the two-requester AES core arbiter.
//   arb_state_e : controller states (IDLE -> ISSUE -> WAIT -> RESP -> IDLE)
//   NREQ        : number of requesters sharing the core
//   W_DEF, TIMEOUT_DEF, TO_W_DEF : default data width, watchdog limit and
//                 watchdog counter width (2**TO_W must exceed TIMEOUT)
`timescale 1ns/1ps
package aes_arb_pkg;

  localparam int NREQ        = 2;
  localparam int W_DEF       = 128;
  localparam int TIMEOUT_DEF = 64;
  localparam int TO_W_DEF    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aes_arb_rr.sv
// Two-way round-robin grant, purely combinational.
//   req       : request bits, bit i = requester i
//   prio      : requester that wins when both request
//   grant_vld : at least one request present
//   grant_idx : index of the granted requester (0 when nothing requests)
`timescale 1ns/1ps
module aes_arb_rr
  import aes_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            prio,
  output logic            grant_vld,
  output logic            grant_idx
);

  always_comb begin
    grant_vld = |req;
    grant_idx = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = prio;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES encryption core between two requesters. One operation is
// outstanding at a time: a plaintext/key pair is latched from the granted
// requester, the core is started with a one-cycle pulse, and the core result
// (or an error after a watchdog timeout) is returned to that requester.
// Ports:
//   clk, rst                 : clock (rising edge), async active-low reset
//   req_valid/req_ready      : per-requester request handshake
//   req_state/req_key        : packed plaintexts/keys, [W-1:0] = REQ0
//   rsp_valid/rsp_ready      : per-requester response handshake
//   rsp_data, rsp_err        : ciphertext (0 on error), timeout flag
//   aes_state/aes_key        : operands to the core, stable ISSUE..WAIT
//   aes_start                : one-cycle start pulse to the core
//   aes_out/aes_done         : core result and completion pulse
//   busy                     : controller not in IDLE
//   owner                    : current / last granted requester
// TIMEOUT legal range is 2..1023.
`timescale 1ns/1ps
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [2*W-1:0]  req_state,
  input  logic [2*W-1:0]  req_key,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_err,
  output logic [W-1:0]    aes_state,
  output logic [W-1:0]    aes_key,
  output logic            aes_start,
  input  logic [W-1:0]    aes_out,
  input  logic            aes_done,
  output logic            busy,
  output logic            owner
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  arb_state_e      r_state;
  arb_state_e      w_next;
  logic            w_gvld;
  logic            w_gidx;
  logic            w_to_hit;
  logic            w_rsp_ack;
  logic            r_prio;
  logic            r_owner;
  logic            r_rsp_err;
  logic [TO_W-1:0] r_wdog;
  logic [W-1:0]    r_aes_state;
  logic [W-1:0]    r_aes_key;
  logic [W-1:0]    r_rsp_data;

  aes_arb_rr u_rr (
    .req       (req_valid),
    .prio      (r_prio),
    .grant_vld (w_gvld),
    .grant_idx (w_gidx)
  );

  assign w_to_hit  = (r_wdog == TO_LAST);
  // Only the owner's rsp_ready can complete a response.
  assign w_rsp_ack = rsp_ready[r_owner];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    aes_start = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        // Gated by rst so req_ready stays low while reset is asserted even
        // if requesters keep their valid lines up.
        if (w_gvld && rst) begin
          req_ready[w_gidx] = 1'b1;
          w_next            = ISSUE;
        end
      end
      ISSUE: begin
        aes_start = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        if (aes_done || w_to_hit) w_next = RESP;
      end
      RESP: begin
        rsp_valid[r_owner] = 1'b1;
        if (w_rsp_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio      <= 1'b0;
      r_owner     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_wdog      <= '0;
      r_aes_state <= '0;
      r_aes_key   <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gvld) begin
            r_owner     <= w_gidx;
            r_aes_state <= w_gidx ? req_state[2*W-1:W] : req_state[W-1:0];
            r_aes_key   <= w_gidx ? req_key[2*W-1:W]   : req_key[W-1:0];
          end
        end
        ISSUE: r_wdog <= '0;
        WAIT: begin
          // A done arriving on the timeout cycle still delivers the result.
          if (aes_done) begin
            r_rsp_data <= aes_out;
            r_rsp_err  <= 1'b0;
          end else begin
            r_wdog <= r_wdog + TO_W'(1);
            if (w_to_hit) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        RESP: begin
          if (w_rsp_ack) r_prio <= ~r_owner;
        end
        default: ;
      endcase
    end
  end

  assign aes_state = r_aes_state;
  assign aes_key   = r_aes_key;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign owner     = r_owner;

endmodule

// File: tb/tb_aes_req_arbiter.sv
`timescale 1ns/1ps
module tb_aes_req_arbiter;
  import aes_arb_pkg::*;

  localparam int W        = 128;
  localparam int TIMEOUT  = 64;
  localparam int TO_W     = 10;
  localparam int CORE_LAT = 11;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  // Non-FIPS operands: the core model returns state ^ key.
  localparam logic [127:0] PT0  = 128'h11111111111111111111111111111111;
  localparam logic [127:0] KEY0 = 128'h22222222222222222222222222222222;
  localparam logic [127:0] EXP0 = 128'h33333333333333333333333333333333;
  localparam logic [127:0] PT1  = 128'h44444444444444444444444444444444;
  localparam logic [127:0] KEY1 = 128'h88888888888888888888888888888888;
  localparam logic [127:0] EXP1 = 128'hcccccccccccccccccccccccccccccccc;
  localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic           clk;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_state;
  logic [2*W-1:0] req_key;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic [W-1:0]   aes_state;
  logic [W-1:0]   aes_key;
  logic           aes_start;
  logic [W-1:0]   aes_out;
  logic           aes_done;
  logic           busy;
  logic           owner;

  logic           core_done;
  logic [W-1:0]   core_out;
  logic           core_busy;
  int             core_cnt;
  logic           core_hang;
  logic           tb_done;
  logic [W-1:0]   tb_out;

  int             n_checks = 0;
  int             n_errors = 0;
  logic [1:0]     g;
  logic [1:0]     eg;
  int             cyc;

  aes_req_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_state (req_state),
    .req_key   (req_key),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .aes_state (aes_state),
    .aes_key   (aes_key),
    .aes_start (aes_start),
    .aes_out   (aes_out),
    .aes_done  (aes_done),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] core_model(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ k;
  endfunction

  // Core model: done pulse CORE_LAT cycles after the start pulse; a hung
  // core never starts. Reset by the same rst as the arbiter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_done <= 1'b0;
      core_out  <= '0;
      core_busy <= 1'b0;
      core_cnt  <= 0;
    end else begin
      core_done <= 1'b0;
      if (aes_start && !core_hang) begin
        core_busy <= 1'b1;
        core_cnt  <= 1;
      end else if (core_busy) begin
        if (core_cnt == CORE_LAT - 1) begin
          core_busy <= 1'b0;
          core_done <= 1'b1;
          core_out  <= core_model(aes_state, aes_key);
        end else begin
          core_cnt <= core_cnt + 1;
        end
      end
    end
  end

  assign aes_done = core_done | tb_done;
  assign aes_out  = tb_done ? tb_out : core_out;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Waits for a grant, returns it, and steps over the accept edge (-> ISSUE).
  task automatic wait_grant(input string tag, output logic [1:0] gr);
    int n;
    n = 0;
    while (req_ready == 2'b00 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_grant_in_time"}, 128'(req_ready != 2'b00), 128'd1);
    gr = req_ready;
    tick();
  endtask

  task automatic wait_rsp(input string tag, output int c);
    c = 0;
    while (rsp_valid == 2'b00 && c < 200) begin
      tick();
      c++;
    end
    chk({tag, "_rsp_in_time"}, 128'(rsp_valid != 2'b00), 128'd1);
  endtask

  task automatic handshake(input logic idx);
    rsp_ready      = 2'b00;
    rsp_ready[idx] = 1'b1;
    tick();
    rsp_ready = 2'b00;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req_valid = 2'b00;
    req_state = '0;
    req_key   = '0;
    rsp_ready = 2'b00;
    core_hang = 1'b0;
    tb_done   = 1'b0;
    tb_out    = '0;
    #3;

    // Reset state
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_data",  rsp_data, 128'd0);
    chk("rst_rsp_err",   128'(rsp_err), 128'd0);
    chk("rst_aes_start", 128'(aes_start), 128'd0);
    chk("rst_busy",      128'(busy), 128'd0);
    chk("rst_owner",     128'(owner), 128'd0);
    chk("rst_aes_state", aes_state, 128'd0);
    chk("rst_aes_key",   aes_key, 128'd0);
    tick();
    rst = 1'b1;
    tick();

    // FIPS-197 vector on REQ0
    req_state[W-1:0] = FIPS_PT;
    req_key[W-1:0]   = FIPS_KEY;
    req_valid        = 2'b01;
    #1;
    wait_grant("fips", g);
    chk("fips_grant", 128'(g), 128'd1);
    req_valid = 2'b00;
    chk("fips_start",     128'(aes_start), 128'd1);
    chk("fips_aes_state", aes_state, FIPS_PT);
    chk("fips_aes_key",   aes_key, FIPS_KEY);
    chk("fips_owner",     128'(owner), 128'd0);
    chk("fips_busy",      128'(busy), 128'd1);
    tick();
    chk("fips_start_pulse", 128'(aes_start), 128'd0);
    wait_rsp("fips", cyc);
    chk("fips_latency",   128'(cyc + 1), 128'd12);
    chk("fips_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("fips_rsp_data",  rsp_data, FIPS_CT);
    chk("fips_rsp_err",   128'(rsp_err), 128'd0);
    handshake(1'b0);
    chk("fips_done_valid", 128'(rsp_valid), 128'd0);
    chk("fips_done_busy",  128'(busy), 128'd0);

    // Stale done in IDLE
    tb_out  = JUNK;
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    #1;
    chk("stale_idle_busy",  128'(busy), 128'd0);
    chk("stale_idle_data",  rsp_data, FIPS_CT);
    chk("stale_idle_valid", 128'(rsp_valid), 128'd0);
    tick();
    chk("stale_idle_busy2", 128'(busy), 128'd0);

    // Simultaneous requests from reset: order 0,1,0
    reset_dut();
    req_state = {PT1, PT0};
    req_key   = {KEY1, KEY0};
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 3; k++) begin
      eg = (k == 1) ? 2'b10 : 2'b01;
      wait_grant("tie", g);
      chk("tie_grant", 128'(g), 128'(eg));
      chk("tie_owner", 128'(owner), 128'(eg[1]));
      wait_rsp("tie", cyc);
      chk("tie_rsp_valid", 128'(rsp_valid), 128'(eg));
      chk("tie_rsp_data",  rsp_data, eg[1] ? EXP1 : EXP0);
      chk("tie_rsp_err",   128'(rsp_err), 128'd0);
      handshake(eg[1]);
    end
    req_valid = 2'b00;
    #1;

    // Backpressure on REQ1's response, REQ0 waiting and poking rsp_ready[0]
    req_valid = 2'b10;
    #1;
    wait_grant("bp", g);
    chk("bp_grant", 128'(g), 128'd2);
    req_valid = 2'b00;
    wait_rsp("bp", cyc);
    req_valid = 2'b01;
    for (int k = 0; k < 20; k++) begin
      rsp_ready = (k == 5) ? 2'b01 : 2'b00;
      #1;
      chk("bp_rsp_valid", 128'(rsp_valid), 128'd2);
      chk("bp_rsp_data",  rsp_data, EXP1);
      chk("bp_rsp_err",   128'(rsp_err), 128'd0);
      chk("bp_req_ready", 128'(req_ready), 128'd0);
      tick();
    end
    rsp_ready = 2'b00;
    #1;
    chk("bp_still_valid", 128'(rsp_valid), 128'd2);
    handshake(1'b1);
    chk("bp_next_ready", 128'(req_ready), 128'd1);
    wait_grant("bp2", g);
    chk("bp2_grant", 128'(g), 128'd1);
    req_valid = 2'b00;
    wait_rsp("bp2", cyc);
    chk("bp2_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("bp2_rsp_data",  rsp_data, EXP0);

    // Stale done in RESP
    tb_out  = JUNK;
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    #1;
    chk("stale_resp_valid", 128'(rsp_valid), 128'd1);
    chk("stale_resp_data",  rsp_data, EXP0);
    chk("stale_resp_err",   128'(rsp_err), 128'd0);
    handshake(1'b0);

    // Watchdog timeout on REQ0
    core_hang = 1'b1;
    req_valid = 2'b01;
    #1;
    wait_grant("to", g);
    chk("to_grant", 128'(g), 128'd1);
    req_valid = 2'b00;
    chk("to_start", 128'(aes_start), 128'd1);
    tick();
    wait_rsp("to", cyc);
    chk("to_latency",   128'(cyc + 1), 128'd65);
    chk("to_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("to_rsp_err",   128'(rsp_err), 128'd1);
    chk("to_rsp_data",  rsp_data, 128'd0);
    tb_out  = JUNK;
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    #1;
    chk("to_late_valid", 128'(rsp_valid), 128'd1);
    chk("to_late_err",   128'(rsp_err), 128'd1);
    chk("to_late_data",  rsp_data, 128'd0);
    handshake(1'b0);
    core_hang = 1'b0;

    // Reset mid-WAIT on a REQ1 operation
    req_valid = 2'b10;
    #1;
    wait_grant("mid", g);
    chk("mid_grant", 128'(g), 128'd2);
    req_valid = 2'b00;
    chk("mid_start", 128'(aes_start), 128'd1);
    for (int k = 0; k < 5; k++) tick();
    chk("mid_busy_before", 128'(busy), 128'd1);
    req_valid = 2'b11;
    rst       = 1'b0;
    #1;
    chk("mid_req_ready", 128'(req_ready), 128'd0);
    chk("mid_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("mid_rsp_data",  rsp_data, 128'd0);
    chk("mid_rsp_err",   128'(rsp_err), 128'd0);
    chk("mid_aes_start", 128'(aes_start), 128'd0);
    chk("mid_busy",      128'(busy), 128'd0);
    chk("mid_owner",     128'(owner), 128'd0);
    chk("mid_aes_state", aes_state, 128'd0);
    chk("mid_aes_key",   aes_key, 128'd0);
    tick();
    rst = 1'b1;
    #1;
    wait_grant("post", g);
    chk("post_grant", 128'(g), 128'd1);
    req_valid = 2'b00;
    wait_rsp("post", cyc);
    chk("post_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("post_rsp_data",  rsp_data, EXP0);
    handshake(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
- Shares one AES encryption core between two requesters (REQ0, REQ1).
- Accepts a plaintext/key pair from one requester at a time, pulses the core start, waits for the core's done, and returns the ciphertext to the requester that issued it.
- Round-robin arbitration, one operation outstanding.
- A watchdog ends any operation whose core never signals done.

Parameters:
- W, 128, width of data and key paths.
- TIMEOUT, 64, max cycles in WAIT before abort; legal range 2..1023.
- TO_W, 10, watchdog counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = REQi.
- req_ready  out  2  per-requester accept; at most one bit high, for 1 cycle.
- req_state  in  2*W  plaintexts; [W-1:0] = REQ0, [2W-1:W] = REQ1.
- req_key  in  2*W  keys, same packing as req_state.
- rsp_valid  out  2  per-requester response valid; at most one bit high.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  W  ciphertext, or 0 on error.
- rsp_err  out  1  qualifies rsp_data: 1 = timeout abort.
- aes_state  out  W  plaintext to core; held stable ISSUE through WAIT.
- aes_key  out  W  key to core; held stable ISSUE through WAIT.
- aes_start  out  1  one-cycle start pulse to core.
- aes_out  in  W  core result; valid only with aes_done.
- aes_done  in  1  one-cycle core completion pulse.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the current/last granted requester.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; rr_prio=0 (REQ0 wins first tie); watchdog=0; latched data/key=0.
- IDLE:
  - If exactly one req_valid bit is set, grant that requester.
  - If both are set, grant rr_prio.
  - In the same cycle: req_ready[g]=1, latch req_state/req_key slice g into aes_state/aes_key, owner<=g, go to ISSUE.
  - With no request, stay in IDLE and hold req_ready=0.
- ISSUE: aes_start=1 for exactly this cycle; watchdog<=0; go to WAIT.
- WAIT:
  - On aes_done: capture rsp_data<=aes_out, rsp_err<=0, go to RESP.
  - Otherwise increment watchdog. When watchdog==TIMEOUT-1 with no done: rsp_data<=0, rsp_err<=1, go to RESP.
  - If aes_done and the timeout hit in the same cycle, aes_done wins.
- RESP:
  - rsp_valid[owner]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[owner]: next cycle rsp_valid=0, rr_prio<=~owner, go to IDLE.
  - rsp_ready on the non-owner bit is ignored.
- aes_done outside WAIT (stale or late): ignored, no state change.
- req_valid is ignored outside IDLE; req_ready=0 in those states. Requesters must hold valid and data until ready.
- Latency: request accept to aes_start = 1 cycle. Core done to rsp_valid = 1 cycle. Min back-to-back turnaround = 1 IDLE cycle after the response handshake.
- Reset mid-operation: immediate return to the reset values; the in-flight result is discarded. The core must be reset by the same rst.
- busy=1 in ISSUE, WAIT and RESP.
- rr_prio is updated only on response completion, including error completions.

Decomposition:
- Package aes_arb_pkg: state enum {IDLE, ISSUE, WAIT, RESP} (2-bit); constant NREQ=2; default W and TIMEOUT.
- Sub-module aes_arb_rr: 2-way round-robin grant (inputs req, prio; outputs grant_vld, grant_idx), purely combinational.
- Everything else (FSM, latches, watchdog) lives in the top block.

Test Plan:
- FIPS-197 vector on REQ0:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff; core model latency 11.
  - Required: aes_start exactly one cycle after req_ready[0]; rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a; rsp_err=0; rsp_valid[0] only.
- Simultaneous requests:
  - Stimulus: REQ0 and REQ1 held valid for three operations from reset.
  - Required: grant order 0,1,0; owner tracks the grant; each result goes to the correct rsp_valid bit.
- Backpressure:
  - Stimulus: hold rsp_ready[1]=0 for 20 cycles; pulse rsp_ready[0] during that time.
  - Required: rsp_valid[1], rsp_data and rsp_err stable throughout; no new grant; req_ready=00 until the REQ1 handshake.
- Timeout:
  - Stimulus: core model never asserts done; TIMEOUT=64.
  - Required: rsp_valid rises exactly 65 cycles after aes_start with rsp_err=1 and rsp_data=0. A late aes_done afterwards is ignored.
- Reset mid-WAIT:
  - Stimulus: drop rst 5 cycles after aes_start.
  - Required: all outputs 0 asynchronously, before the next edge. After release, the first tie is granted to REQ0.
- Stale done:
  - Stimulus: pulse aes_done in IDLE and in RESP.
  - Required: no state change; rsp_data unchanged.
